// File: rtl/fetch_queue_pkg.sv
// Shared word and fetch-packet types, plus the lowest legal instruction address.
package types;
   typedef logic [31:0] word_t;

   typedef struct packed {
      word_t pc;
      word_t instr;
   } fetch_pkt_t;
endpackage

package addressing;
   localparam logic [31:0] BaseAddress = 32'h8000_0000;
endpackage

// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling FIFO: registered storage, one-cycle flush on redirect,
// and a ready that ignores decode so there is no combinational decode-to-fetch path.
module fetch_queue
   import types::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic                       enq_valid_i,
   output logic                       enq_ready_o,
   input  word_t                      enq_pc_i,
   input  word_t                      enq_instr_i,
   output logic                       deq_valid_o,
   input  logic                       deq_ready_i,
   output word_t                      deq_pc_o,
   output word_t                      deq_instr_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);
   localparam logic [CntW-1:0] CountFull = CntW'(DEPTH);

   fetch_pkt_t      mem_q [DEPTH];
   fetch_pkt_t      mem_d [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            enq_fire;
   logic            deq_fire;

   // Flush and reset mask both handshakes so nothing moves in those cycles.
   always_comb begin
      enq_ready_o = (count_q != CountFull) && !flush_i && !rst_i;
      deq_valid_o = (count_q != {CntW{1'b0}}) && !flush_i && !rst_i;
      enq_fire    = enq_valid_i && enq_ready_o;
      deq_fire    = deq_valid_o && deq_ready_i;
   end

   assign deq_pc_o    = mem_q[rd_ptr_q].pc;
   assign deq_instr_o = mem_q[rd_ptr_q].instr;
   assign count_o     = count_q;

   // Pointer and occupancy next-state; pointers wrap by natural overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = wr_ptr_q;
         count_d  = {CntW{1'b0}};
      end else begin
         if (enq_fire) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (deq_fire) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({enq_fire, deq_fire})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Storage write: only the slot under wr_ptr changes, and only on an accepted packet.
   always_comb begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         mem_d[i] = mem_q[i];
      end
      if (enq_fire) begin
         mem_d[wr_ptr_q] = {enq_pc_i, enq_instr_i};
      end else begin
         mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
      end
   end

   // Control state register; reset outranks flush.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= {PtrW{1'b0}};
         rd_ptr_q <= {PtrW{1'b0}};
         count_q  <= {CntW{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage register; contents are don't-care until written, so it is never reset.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         mem_q[i] <= mem_d[i];
      end
   end

`ifndef NDEBUG
   // Debug checks on accepted packets and bookkeeping consistency.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         if (enq_fire) begin
            assert (enq_pc_i[1:0] == 2'b00) else $fatal(1, "misaligned pc");
            assert (enq_pc_i >= addressing::BaseAddress) else $fatal(1, "pc below base address");
         end
         assert (int'(count_q) <= int'(DEPTH)) else $fatal(1, "count exceeds depth");
         assert ((count_q != {CntW{1'b0}}) || (wr_ptr_q == rd_ptr_q))
            else $fatal(1, "empty queue with unequal pointers");
      end
   end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of the FIFO rules.
module tb_fetch_queue;
   import types::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = $clog2(DEPTH + 1);
   localparam word_t       BA    = addressing::BaseAddress;

   logic          clk_i = 1'b0;
   logic          rst_i, flush_i, enq_valid_i, deq_ready_i;
   word_t         enq_pc_i, enq_instr_i, deq_pc_o, deq_instr_o;
   logic          enq_ready_o, deq_valid_o;
   logic [CW-1:0] count_o;

   int         checks = 0;
   int         errors = 0;
   fetch_pkt_t mq[$];

   always #5 clk_i = ~clk_i;

   fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .enq_valid_i (enq_valid_i),
      .enq_ready_o (enq_ready_o),
      .enq_pc_i    (enq_pc_i),
      .enq_instr_i (enq_instr_i),
      .deq_valid_o (deq_valid_o),
      .deq_ready_i (deq_ready_i),
      .deq_pc_o    (deq_pc_o),
      .deq_instr_o (deq_instr_o),
      .count_o     (count_o)
   );

   // Reference model: a plain queue of packets plus the ready/valid rules.
   function automatic bit m_rdy();
      return !rst_i && !flush_i && (mq.size() != int'(DEPTH));
   endfunction

   function automatic bit m_vld();
      return !rst_i && !flush_i && (mq.size() != 0);
   endfunction

   task automatic drive(input logic rst, input logic fl, input logic ev,
                        input word_t pc, input word_t ins, input logic dr);
      rst_i = rst; flush_i = fl; enq_valid_i = ev;
      enq_pc_i = pc; enq_instr_i = ins; deq_ready_i = dr;
      #1;
   endtask

   task automatic tick();
      bit ef, df;
      ef = enq_valid_i && m_rdy();
      df = deq_ready_i && m_vld();
      @(posedge clk_i);
      if (rst_i || flush_i) begin
         mq.delete();
      end else begin
         if (df) void'(mq.pop_front());
         if (ef) mq.push_back({enq_pc_i, enq_instr_i});
      end
      @(negedge clk_i);
   endtask

   task automatic test_reset();
      for (int c = 0; c < 2; c++) begin
         drive(1'b1, 1'b0, 1'b1, BA, 32'h0000_0013, 1'b0);
         checks += 2;
         if (enq_ready_o !== 1'b0) begin errors++; $display("FAIL reset_enq_ready: got %b expected 0", enq_ready_o); end
         if (deq_valid_o !== 1'b0) begin errors++; $display("FAIL reset_deq_valid: got %b expected 0", deq_valid_o); end
         tick();
         checks++;
         if (count_o !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count_o); end
      end
      drive(1'b0, 1'b0, 1'b0, BA, 32'h0, 1'b0);
      checks += 3;
      if (enq_ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_enq_ready: got %b expected 1", enq_ready_o); end
      if (deq_valid_o !== 1'b0) begin errors++; $display("FAIL post_reset_deq_valid: got %b expected 0", deq_valid_o); end
      if (count_o !== '0) begin errors++; $display("FAIL post_reset_count: got %0d expected 0", count_o); end
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, 1'b1, BA + word_t'(4 * i), $urandom, 1'b0);
         checks += 2;
         if (enq_ready_o !== m_rdy()) begin errors++; $display("FAIL fill_enq_ready[%0d]: got %b expected %b", i, enq_ready_o, m_rdy()); end
         if (count_o !== CW'(i < 4 ? i : 4)) begin errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count_o, (i < 4 ? i : 4)); end
         if (i == 4) begin
            checks++;
            if (enq_ready_o !== 1'b0) begin errors++; $display("FAIL full_enq_ready: got %b expected 0", enq_ready_o); end
         end
         tick();
      end
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, 1'b0, BA, 32'h0, 1'b1);
         checks += 2;
         if (deq_valid_o !== (i < 4)) begin errors++; $display("FAIL drain_valid[%0d]: got %b expected %b", i, deq_valid_o, (i < 4)); end
         if (count_o !== CW'(4 - (i < 4 ? i : 4))) begin errors++; $display("FAIL drain_count[%0d]: got %0d", i, count_o); end
         if (m_vld()) begin
            checks += 2;
            if (deq_pc_o !== BA + word_t'(4 * i)) begin errors++; $display("FAIL drain_pc[%0d]: got %h expected %h", i, deq_pc_o, BA + word_t'(4 * i)); end
            if ({deq_pc_o, deq_instr_o} !== mq[0]) begin errors++; $display("FAIL drain_pkt[%0d]: got %h expected %h", i, {deq_pc_o, deq_instr_o}, mq[0]); end
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k <= 20; k++) begin
         drive(1'b0, 1'b0, (k < 20), BA + 32'h100 + word_t'(4 * k), 32'h0000_0013, 1'b1);
         checks += 2;
         if (enq_ready_o !== m_rdy()) begin errors++; $display("FAIL b2b_enq_ready[%0d]: got %b expected %b", k, enq_ready_o, m_rdy()); end
         if (count_o !== CW'(k == 0 ? 0 : 1)) begin errors++; $display("FAIL b2b_count[%0d]: got %0d expected %0d", k, count_o, (k == 0 ? 0 : 1)); end
         if (k > 0) begin
            checks += 3;
            if (deq_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b expected 1", k, deq_valid_o); end
            if (deq_pc_o !== BA + 32'h100 + word_t'(4 * (k - 1))) begin errors++; $display("FAIL b2b_pc[%0d]: got %h expected %h", k, deq_pc_o, BA + 32'h100 + word_t'(4 * (k - 1))); end
            if (deq_instr_o !== 32'h0000_0013) begin errors++; $display("FAIL b2b_instr[%0d]: got %h expected 00000013", k, deq_instr_o); end
         end
         tick();
      end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b1, BA + 32'h200 + word_t'(4 * i), $urandom, 1'b0);
         tick();
      end
      drive(1'b0, 1'b1, 1'b1, BA + 32'h20c, 32'h1, 1'b1);
      checks += 3;
      if (count_o !== CW'(3)) begin errors++; $display("FAIL flush_pre_count: got %0d expected 3", count_o); end
      if (enq_ready_o !== 1'b0) begin errors++; $display("FAIL flush_enq_ready: got %b expected 0", enq_ready_o); end
      if (deq_valid_o !== 1'b0) begin errors++; $display("FAIL flush_deq_valid: got %b expected 0", deq_valid_o); end
      tick();
      drive(1'b0, 1'b0, 1'b1, BA + 32'h40, 32'hdead_beef, 1'b0);
      checks += 3;
      if (count_o !== '0) begin errors++; $display("FAIL flush_post_count: got %0d expected 0", count_o); end
      if (deq_valid_o !== 1'b0) begin errors++; $display("FAIL flush_post_valid: got %b expected 0", deq_valid_o); end
      if (enq_ready_o !== 1'b1) begin errors++; $display("FAIL flush_post_ready: got %b expected 1", enq_ready_o); end
      tick();
      drive(1'b0, 1'b0, 1'b0, BA, 32'h0, 1'b1);
      checks += 3;
      if (deq_valid_o !== 1'b1) begin errors++; $display("FAIL redirect_valid: got %b expected 1", deq_valid_o); end
      if (deq_pc_o !== BA + 32'h40) begin errors++; $display("FAIL redirect_pc: got %h expected %h", deq_pc_o, BA + 32'h40); end
      if (deq_instr_o !== 32'hdead_beef) begin errors++; $display("FAIL redirect_instr: got %h expected deadbeef", deq_instr_o); end
      tick();
   endtask

   task automatic test_full_deq();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 1'b1, BA + 32'h300 + word_t'(4 * i), $urandom, 1'b0);
         tick();
      end
      drive(1'b0, 1'b0, 1'b1, BA + 32'h310, 32'h0000_0aaa, 1'b1);
      checks += 3;
      if (count_o !== CW'(4)) begin errors++; $display("FAIL fulldeq_count: got %0d expected 4", count_o); end
      if (enq_ready_o !== 1'b0) begin errors++; $display("FAIL fulldeq_enq_ready: got %b expected 0", enq_ready_o); end
      if (deq_valid_o !== 1'b1) begin errors++; $display("FAIL fulldeq_deq_valid: got %b expected 1", deq_valid_o); end
      tick();
      drive(1'b0, 1'b0, 1'b1, BA + 32'h310, 32'h0000_0aaa, 1'b0);
      checks += 2;
      if (count_o !== CW'(3)) begin errors++; $display("FAIL fulldeq_after_count: got %0d expected 3", count_o); end
      if (enq_ready_o !== 1'b1) begin errors++; $display("FAIL fulldeq_retry_ready: got %b expected 1", enq_ready_o); end
      tick();
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, 1'b0, BA, 32'h0, 1'b1);
         checks += 2;
         if (deq_valid_o !== m_vld()) begin errors++; $display("FAIL fulldeq_drain_valid[%0d]: got %b expected %b", i, deq_valid_o, m_vld()); end
         if (count_o !== CW'(mq.size())) begin errors++; $display("FAIL fulldeq_drain_count[%0d]: got %0d expected %0d", i, count_o, mq.size()); end
         if (m_vld()) begin
            checks++;
            if ({deq_pc_o, deq_instr_o} !== mq[0]) begin errors++; $display("FAIL fulldeq_drain_pkt[%0d]: got %h expected %h", i, {deq_pc_o, deq_instr_o}, mq[0]); end
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b0, 1'b1, BA + 32'h400 + word_t'(4 * i), $urandom, 1'b0);
         tick();
      end
      drive(1'b1, 1'b0, 1'b1, BA + 32'h408, 32'h5, 1'b0);
      checks++;
      if (count_o !== CW'(2)) begin errors++; $display("FAIL rstmid_pre_count: got %0d expected 2", count_o); end
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b0, BA, 32'h0, 1'b1);
         checks += 2;
         if (count_o !== '0) begin errors++; $display("FAIL rstmid_count[%0d]: got %0d expected 0", i, count_o); end
         if (deq_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_stale[%0d]: got %b expected 0", i, deq_valid_o); end
         tick();
      end
   endtask

   task automatic test_random();
      word_t pc = BA + 32'h1000;
      for (int k = 0; k < 400; k++) begin
         drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 9) < 7), pc, $urandom, ($urandom_range(0, 9) < 6));
         checks += 3;
         if (enq_ready_o !== m_rdy()) begin errors++; $display("FAIL rand_enq_ready[%0d]: got %b expected %b", k, enq_ready_o, m_rdy()); end
         if (deq_valid_o !== m_vld()) begin errors++; $display("FAIL rand_deq_valid[%0d]: got %b expected %b", k, deq_valid_o, m_vld()); end
         if (!rst_i && count_o !== CW'(mq.size())) begin errors++; $display("FAIL rand_count[%0d]: got %0d expected %0d", k, count_o, mq.size()); end
         if (m_vld()) begin
            checks++;
            if ({deq_pc_o, deq_instr_o} !== mq[0]) begin errors++; $display("FAIL rand_pkt[%0d]: got %h expected %h", k, {deq_pc_o, deq_instr_o}, mq[0]); end
         end
         if (enq_valid_i && m_rdy()) pc = pc + 32'd4;
         tick();
      end
   endtask

   initial begin
      drive(1'b1, 1'b0, 1'b0, BA, 32'h0, 1'b0);
      @(negedge clk_i);
      test_reset();
      test_fill_drain();
      test_back_to_back();
      test_flush();
      test_full_deq();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
